// File: rtl/regbank_wr_arbiter_if.sv
// Write-side bundle between the requesters, the arbiter and the 32x32 register bank.
// Latency: none (signal grouping only).
// Backpressure: per-requester valid/ready; the bank side has no backpressure.
interface regbank_wr_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    localparam int GID_W = $clog2(N_REQ);

    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ-1:0]        req_ready;
    logic [N_REQ*ADDR_W-1:0] req_addr;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic                    write;
    logic [ADDR_W-1:0]       dr;
    logic [DATA_W-1:0]       wrData;
    logic [GID_W-1:0]        grant_id;

    // Requester / bank side
    modport master (
        output req_valid, req_addr, req_data,
        input  req_ready, write, dr, wrData, grant_id
    );

    // Arbiter side
    modport slave (
        input  req_valid, req_addr, req_data,
        output req_ready, write, dr, wrData, grant_id
    );
endinterface

// File: rtl/regbank_wr_arbiter.sv
// Round-robin arbiter sharing the register bank write port among N_REQ requesters, plus a bulk zero-clear sweep.
// Latency: accept edge -> registered write strobe for exactly the next cycle; one write per cycle back-to-back.
// Backpressure: ready is granted to at most one valid requester; all ready low while clearing or when init_start is seen.
module regbank_wr_arbiter #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 init_start,
    output logic                 init_busy,
    regbank_wr_arbiter_if.slave  bus
);
    localparam int GID_W = $clog2(N_REQ);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {S_RUN, S_CLEAR} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [GID_W-1:0]   r_rr_ptr;
    logic [ADDR_W-1:0]  r_clr_cnt;
    logic               r_write;
    logic [ADDR_W-1:0]  r_dr;
    logic [DATA_W-1:0]  r_wr_data;
    logic [GID_W-1:0]   r_grant_id;

    logic               w_any;
    logic [GID_W-1:0]   w_pick;
    logic [GID_W-1:0]   w_rr_nxt;
    logic [N_REQ-1:0]   w_ready;
    int                 w_idx;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_RUN;
        else        r_state <= w_state_nxt;
    end

    // Next state and round-robin pick: search rr_ptr, rr_ptr+1, ... for the first valid requester
    always_comb begin
        w_state_nxt = r_state;
        w_any       = 1'b0;
        w_pick      = '0;
        w_idx       = 0;
        w_ready     = '0;
        case (r_state)
            S_RUN: begin
                if (init_start) begin
                    w_state_nxt = S_CLEAR;
                end else begin
                    for (int k = 0; k < N_REQ; k++) begin
                        w_idx = (int'(r_rr_ptr) + k) % N_REQ;
                        if (!w_any && bus.req_valid[w_idx]) begin
                            w_any  = 1'b1;
                            w_pick = GID_W'(w_idx);
                        end
                    end
                    if (w_any) w_ready[w_pick] = 1'b1;
                end
            end
            S_CLEAR: begin
                if (r_clr_cnt == ADDR_W'(DEPTH - 1)) w_state_nxt = S_RUN;
            end
            default: w_state_nxt = S_RUN;
        endcase
        w_rr_nxt = (w_pick == GID_W'(N_REQ - 1)) ? '0 : w_pick + 1'b1;
    end

    // Write port registers, rotating pointer and clear sweep counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr   <= '0;
            r_clr_cnt  <= '0;
            r_write    <= 1'b0;
            r_dr       <= '0;
            r_wr_data  <= '0;
            r_grant_id <= '0;
        end else if (r_state == S_CLEAR) begin
            r_write    <= 1'b1;
            r_dr       <= r_clr_cnt;
            r_wr_data  <= '0;
            r_grant_id <= '0;
            r_clr_cnt  <= (r_clr_cnt == ADDR_W'(DEPTH - 1)) ? '0 : r_clr_cnt + 1'b1;
        end else begin
            r_write <= w_any;
            if (w_any) begin
                r_dr       <= bus.req_addr[int'(w_pick) * ADDR_W +: ADDR_W];
                r_wr_data  <= bus.req_data[int'(w_pick) * DATA_W +: DATA_W];
                r_grant_id <= w_pick;
                r_rr_ptr   <= w_rr_nxt;
            end
        end
    end

    // Ready is forced low while reset is asserted so no requester sees a grant in reset
    assign bus.req_ready = rst_n ? w_ready : '0;
    assign bus.write     = r_write;
    assign bus.dr        = r_dr;
    assign bus.wrData    = r_wr_data;
    assign bus.grant_id  = r_grant_id;
    assign init_busy     = (r_state == S_CLEAR);
endmodule

// File: tb/tb_regbank_wr_arbiter.sv
// Directed bench for regbank_wr_arbiter with a behavioural 32x32 bank on the write port.
// Latency: checks registered outputs 1 time unit after each rising edge, ready 2 units after.
// Backpressure: requester valids are driven per step and held until accepted.
module tb_regbank_wr_arbiter;
    localparam int N_REQ  = 4;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    logic clk;
    logic rst_n;
    logic init_start;
    logic init_busy;

    int n_vec;
    int n_err;
    int nz;
    logic [DATA_W-1:0] bank [32];

    regbank_wr_arbiter_if #(.N_REQ(N_REQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    regbank_wr_arbiter #(.N_REQ(N_REQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .init_start (init_start),
        .init_busy  (init_busy),
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bank model: captures each write strobe
    always @(posedge clk) begin
        if (bus.write) bank[bus.dr] <= bus.wrData;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        bus.req_addr[i*ADDR_W +: ADDR_W] = a;
        bus.req_data[i*DATA_W +: DATA_W] = d;
    endtask

    task automatic chk_wr(input string tag, input logic w, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] d, input logic [1:0] g);
        chk({tag, "_write"}, 64'(bus.write), 64'(w));
        chk({tag, "_dr"}, 64'(bus.dr), 64'(a));
        chk({tag, "_wrData"}, 64'(bus.wrData), 64'(d));
        chk({tag, "_gid"}, 64'(bus.grant_id), 64'(g));
    endtask

    initial begin
        logic [3:0] exp_rdy;
        logic [1:0] g;
        n_vec = 0;
        n_err = 0;
        for (int i = 0; i < 32; i++) bank[i] = 32'hFFFF_FFFF;
        rst_n = 1'b1;
        init_start = 1'b0;
        bus.req_valid = 4'hF;
        for (int i = 0; i < N_REQ; i++) set_req(i, ADDR_W'(i), 32'hA0 + 32'(i));
        #1 rst_n = 1'b0;

        // Reset state, with all requesters already valid
        #2;
        chk_wr("reset", 1'b0, 5'd0, 32'd0, 2'd0);
        chk("reset_busy", 64'(init_busy), 64'(0));
        chk("reset_ready", 64'(bus.req_ready), 64'(0));
        #9 rst_n = 1'b1;
        #1 chk("t1_ready0", 64'(bus.req_ready), 64'(4'b0001));

        // Test 1: all valid -> round-robin 0,1,2,3,0,...
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            g = 2'(c % 4);
            chk_wr("t1_grant", 1'b1, ADDR_W'(g), 32'hA0 + 32'(g), g);
            if (c == 7) begin
                bus.req_valid = 4'b0100;
                set_req(2, 5'd7, 32'hDEAD_BEEF);
                exp_rdy = 4'b0100;
            end else begin
                exp_rdy = 4'(1 << ((c + 1) % 4));
            end
            #1 chk("t1_ready", 64'(bus.req_ready), 64'(exp_rdy));
        end

        // Test 2: only req 2 valid
        @(posedge clk); #1;
        chk_wr("t2_grant", 1'b1, 5'd7, 32'hDEAD_BEEF, 2'd2);
        bus.req_valid = 4'b0000;
        @(posedge clk); #1;
        chk_wr("t2_idle", 1'b0, 5'd7, 32'hDEAD_BEEF, 2'd2);

        // Bring rr_ptr back to 0 via a grant to req 3
        bus.req_valid = 4'b1000;
        set_req(3, 5'd9, 32'h99);
        @(posedge clk); #1;
        chk_wr("t3_pre", 1'b1, 5'd9, 32'h99, 2'd3);

        // Test 3: req 1 and 3 both write reg 5, req 1 first
        bus.req_valid = 4'b1010;
        set_req(1, 5'd5, 32'h11);
        set_req(3, 5'd5, 32'h33);
        #1 chk("t3_ready1", 64'(bus.req_ready), 64'(4'b0010));
        @(posedge clk); #1;
        chk_wr("t3_first", 1'b1, 5'd5, 32'h11, 2'd1);
        bus.req_valid = 4'b1000;
        #1 chk("t3_ready3", 64'(bus.req_ready), 64'(4'b1000));
        @(posedge clk); #1;
        chk_wr("t3_second", 1'b1, 5'd5, 32'h33, 2'd3);
        bus.req_valid = 4'b0000;
        @(posedge clk); #1;
        chk("t3_idle", 64'(bus.write), 64'(0));
        chk("t3_bank5", 64'(bank[5]), 64'(32'h33));

        // Test 4: init_start with req 0 pending -> 32-cycle clear sweep
        bus.req_valid = 4'b0001;
        set_req(0, 5'd3, 32'h55);
        init_start = 1'b1;
        #1 chk("t4_ready_init", 64'(bus.req_ready), 64'(0));
        @(posedge clk); #1;
        init_start = 1'b0;
        chk("t4_busy0", 64'(init_busy), 64'(1));
        chk("t4_nowrite", 64'(bus.write), 64'(0));
        #1 chk("t4_ready_clr", 64'(bus.req_ready), 64'(0));
        for (int k = 0; k < 32; k++) begin
            @(posedge clk); #1;
            chk_wr("t4_clr", 1'b1, ADDR_W'(k), 32'd0, 2'd0);
            chk("t4_busy", 64'(init_busy), 64'(k < 31));
        end
        #1 chk("t4_ready_after", 64'(bus.req_ready), 64'(4'b0001));
        @(posedge clk); #1;
        nz = 0;
        for (int i = 0; i < 32; i++) if (bank[i] !== 32'd0) nz++;
        chk("t4_bank_nonzero", 64'(nz), 64'(0));
        chk_wr("t4_req0", 1'b1, 5'd3, 32'h55, 2'd0);
        bus.req_valid = 4'b0000;

        // Test 5: reset asserted with clr_cnt=10 (rr_ptr is 1 beforehand)
        init_start = 1'b1;
        @(posedge clk); #1;
        init_start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk_wr("t5_pre", 1'b1, 5'd9, 32'd0, 2'd0);
        chk("t5_busy_pre", 64'(init_busy), 64'(1));
        rst_n = 1'b0;
        #1;
        chk_wr("t5_rst", 1'b0, 5'd0, 32'd0, 2'd0);
        chk("t5_busy_rst", 64'(init_busy), 64'(0));
        #1 rst_n = 1'b1;
        bus.req_valid = 4'b1001;
        set_req(3, 5'd20, 32'h2020);
        #1;
        chk("t5_ready_ptr0", 64'(bus.req_ready), 64'(4'b0001));
        chk("t5_busy_rel", 64'(init_busy), 64'(0));
        @(posedge clk); #1;
        chk_wr("t5_grant0", 1'b1, 5'd3, 32'h55, 2'd0);
        bus.req_valid = 4'b1000;
        #1 chk("t5_ready3", 64'(bus.req_ready), 64'(4'b1000));
        @(posedge clk); #1;
        chk_wr("t5_grant3", 1'b1, 5'd20, 32'h2020, 2'd3);

        // Test 6: req 0 withdraws while req 1 pending, rr_ptr=0
        bus.req_valid = 4'b0011;
        set_req(1, 5'd12, 32'h1212);
        #1 chk("t6_ready0", 64'(bus.req_ready), 64'(4'b0001));
        bus.req_valid = 4'b0010;
        #1 chk("t6_ready1", 64'(bus.req_ready), 64'(4'b0010));
        @(posedge clk); #1;
        chk_wr("t6_grant1", 1'b1, 5'd12, 32'h1212, 2'd1);
        bus.req_valid = 4'b1010;
        #1 chk("t6_ptr2", 64'(bus.req_ready), 64'(4'b1000));
        bus.req_valid = 4'b0000;
        @(posedge clk); #1;
        chk("t6_idle", 64'(bus.write), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
